// File: rtl/priv_1_12_pma_regions_pkg.sv
// Package pma_types_1_12_pkg: PMA attribute types shared by the region checker.
//  - pma_cfg_t         : 12-bit attribute word {AccWidth, Rsrv, MemType, Cacheable,
//                        Idempotent, AMO, Coherent, R, W, X}
//  - pma_region_cfg_t  : per-region control {L, EN, pma_cfg_t}
//  - pma_fault_cause_t : fault record cause code (1=load, 2=store, 3=fetch)
//  - CSR page/address constants, ROM/RAM/IO/NONE attribute constants
//  - helpers: WARL legalisation, access-fault test, reset region map
package pma_types_1_12_pkg;

  typedef enum logic [1:0] {
    ByteAcc      = 2'b00,
    HalfAcc      = 2'b01,
    WordAcc      = 2'b10,
    AccWidthRsrv = 2'b11
  } pma_accwidth_t;

  typedef enum logic [1:0] {
    RsrvNone        = 2'b00,
    RsrvNonEventual = 2'b01,
    RsrvEventual    = 2'b10,
    RsrvReserved    = 2'b11
  } pma_rsrv_t;

  typedef struct packed {
    pma_accwidth_t AccWidth;
    pma_rsrv_t     Rsrv;
    logic          MemType;
    logic          Cacheable;
    logic          Idempotent;
    logic          AMO;
    logic          Coherent;
    logic          R;
    logic          W;
    logic          X;
  } pma_cfg_t;

  typedef struct packed {
    logic     L;
    logic     EN;
    pma_cfg_t cfg;
  } pma_region_cfg_t;

  typedef enum logic [1:0] {
    FAULT_NONE  = 2'd0,
    FAULT_LOAD  = 2'd1,
    FAULT_STORE = 2'd2,
    FAULT_FETCH = 2'd3
  } pma_fault_cause_t;

  localparam logic [7:0]  PMA_CFG_PAGE   = 8'hBC;
  localparam logic [7:0]  PMA_BASE_PAGE  = 8'hBD;
  localparam logic [7:0]  PMA_LIMIT_PAGE = 8'hBE;
  localparam logic [7:0]  PMA_FAULT_PAGE = 8'hBF;
  localparam logic [11:0] PMA_FAULT_ADDR_CSR  = 12'hBF0;
  localparam logic [11:0] PMA_FAULT_CAUSE_CSR = 12'hBF1;
  localparam logic [11:0] PMA_FAULT_COUNT_CSR = 12'hBF2;

  localparam pma_cfg_t PMA_CFG_ROM  = pma_cfg_t'(12'h8E5); // word, cached, R X
  localparam pma_cfg_t PMA_CFG_RAM  = pma_cfg_t'(12'h8FF); // word, cached, AMO, R W X
  localparam pma_cfg_t PMA_CFG_IO   = pma_cfg_t'(12'h806); // word, uncached, R W
  localparam pma_cfg_t PMA_CFG_NONE = pma_cfg_t'(12'h000); // no permissions

  // Reserved encodings are mapped to a legal value on write.
  function automatic pma_cfg_t pma_cfg_warl(input logic [11:0] raw);
    pma_cfg_t c;
    c = pma_cfg_t'(raw);
    c.Rsrv     = (c.Rsrv == RsrvReserved) ? RsrvNone : c.Rsrv;
    c.AccWidth = (c.AccWidth == AccWidthRsrv) ? WordAcc : c.AccWidth;
    return c;
  endfunction

  function automatic logic pma_access_fault(input logic req, input logic perm,
                                            input logic [1:0] width,
                                            input pma_accwidth_t max_width);
    return req && (!perm || (width > max_width));
  endfunction

  function automatic pma_region_cfg_t pma_reset_cfg(input int idx);
    case (idx)
      0:       return '{L: 1'b0, EN: 1'b1, cfg: PMA_CFG_ROM};
      1:       return '{L: 1'b0, EN: 1'b1, cfg: PMA_CFG_RAM};
      2:       return '{L: 1'b0, EN: 1'b1, cfg: PMA_CFG_IO};
      default: return '{L: 1'b0, EN: 1'b0, cfg: PMA_CFG_NONE};
    endcase
  endfunction

  function automatic logic [31:0] pma_reset_base(input int idx);
    case (idx)
      1:       return 32'h1000_0000;
      2:       return 32'h8000_0000;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] pma_reset_limit(input int idx);
    case (idx)
      0:       return 32'h0FFF_FFFF;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/priv_1_12_pma_regions_if.sv
// CSR-side bus of the PMA region checker (priv_ext_if style).
//  csr_addr/csr_active/value_in : request from the CSR unit (master)
//  value_out/ack/invalid_csr    : response from the PMA block (slave)
interface priv_1_12_pma_regions_if;
  logic [11:0] csr_addr;
  logic        csr_active;
  logic [31:0] value_in;
  logic [31:0] value_out;
  logic        ack;
  logic        invalid_csr;

  modport master (output csr_addr, csr_active, value_in,
                  input  value_out, ack, invalid_csr);
  modport slave  (input  csr_addr, csr_active, value_in,
                  output value_out, ack, invalid_csr);
endinterface

// File: rtl/priv_1_12_pma_match.sv
// One region compare: hit when the region is enabled and
// base <= addr <= limit (all in granule units). limit < base never hits.
//  en, base, limit : region state
//  addr            : address granule under test
//  hit             : region matches
module priv_1_12_pma_match #(
  parameter int AW = 20
) (
  input  logic          en,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] limit,
  input  logic [AW-1:0] addr,
  output logic          hit
);
  assign hit = en && (base <= addr) && (addr <= limit);
endmodule

// File: rtl/priv_1_12_pma_regions.sv
// Programmable PMA checker: NREGIONS base/limit regions, lowest matching
// index wins, unmatched accesses see the NONE attributes and fault.
// Ports:
//  CLK, nRST                      clock, async active-low reset
//  csr_if (slave)                 CSR access: cfg 0xBC0+n, base 0xBD0+n,
//                                 limit 0xBE0+n, fault addr/cause/count 0xBF0-2
//  daddr/iaddr, ren/wen/xen       data/instruction access requests
//  d_acc_width/i_acc_width        00 byte, 01 half, 10 word
//  pma_l/s/i_fault                one-cycle registered fault pulses
//  fault_pend                     sticky fault record holds an entry
// Build option: PMA_FAULT_COUNT_EN adds a 16-bit saturating fault counter at 0xBF2.
module priv_1_12_pma_regions
  import pma_types_1_12_pkg::*;
#(
  parameter int NREGIONS  = 8,
  parameter int GRAN_LOG2 = 12
) (
  input  logic                    CLK,
  input  logic                    nRST,
  priv_1_12_pma_regions_if.slave  csr_if,
  input  logic [31:0]             daddr,
  input  logic [31:0]             iaddr,
  input  logic                    ren,
  input  logic                    wen,
  input  logic                    xen,
  input  logic [1:0]              d_acc_width,
  input  logic [1:0]              i_acc_width,
  output logic                    pma_l_fault,
  output logic                    pma_s_fault,
  output logic                    pma_i_fault,
  output logic                    fault_pend
);
  localparam int GW = 32 - GRAN_LOG2;

  typedef enum logic {REC_IDLE, REC_HELD} rec_state_t;

  pma_region_cfg_t  cfg_r   [NREGIONS];
  logic [GW-1:0]    base_r  [NREGIONS];
  logic [GW-1:0]    limit_r [NREGIONS];
  logic [NREGIONS-1:0] d_hit_s, i_hit_s;
  pma_cfg_t         dcfg_s, icfg_s;
  logic             l_flag_s, s_flag_s, i_flag_s, any_fault_s;
  logic             l_raw_s, s_raw_s, i_raw_s;
  pma_fault_cause_t cause_s, rec_cause_r;
  logic [31:0]      fault_addr_s, rec_addr_r, rdata_s, count_rd_s;
  rec_state_t       state_r, next_s;
  logic             capture_s, clear_s;
  logic [7:0]       page_s;
  logic [3:0]       idx_s;
  logic             region_page_s, idx_ok_s;
  logic             unused_s;

  assign page_s        = csr_if.csr_addr[11:4];
  assign idx_s         = csr_if.csr_addr[3:0];
  assign idx_ok_s      = int'(idx_s) < NREGIONS;
  assign region_page_s = (page_s == PMA_CFG_PAGE) || (page_s == PMA_BASE_PAGE) ||
                         (page_s == PMA_LIMIT_PAGE);
  assign csr_if.ack    = region_page_s ||
                         ((page_s == PMA_FAULT_PAGE) && (idx_s <= 4'd2));
  assign csr_if.invalid_csr = region_page_s && !idx_ok_s;
  assign csr_if.value_out   = rdata_s;
  assign clear_s = csr_if.csr_active && (csr_if.csr_addr == PMA_FAULT_CAUSE_CSR);
  assign unused_s = ^{csr_if.value_in, daddr, iaddr};

  for (genvar g = 0; g < NREGIONS; g++) begin : g_region
    priv_1_12_pma_match #(.AW(GW)) u_dmatch (
      .en(cfg_r[g].EN), .base(base_r[g]), .limit(limit_r[g]),
      .addr(daddr[31:GRAN_LOG2]), .hit(d_hit_s[g]));
    priv_1_12_pma_match #(.AW(GW)) u_imatch (
      .en(cfg_r[g].EN), .base(base_r[g]), .limit(limit_r[g]),
      .addr(iaddr[31:GRAN_LOG2]), .hit(i_hit_s[g]));
  end

  // Region registers: reset map, locked regions ignore writes.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NREGIONS; i++) begin
        cfg_r[i]   <= pma_reset_cfg(i);
        base_r[i]  <= GW'(pma_reset_base(i) >> GRAN_LOG2);
        limit_r[i] <= GW'(pma_reset_limit(i) >> GRAN_LOG2);
      end
    end else begin
      for (int i = 0; i < NREGIONS; i++) begin
        if (csr_if.csr_active && (idx_s == 4'(i)) && !cfg_r[i].L) begin
          case (page_s)
            PMA_CFG_PAGE:   cfg_r[i] <= '{L: csr_if.value_in[31], EN: csr_if.value_in[30],
                                          cfg: pma_cfg_warl(csr_if.value_in[11:0])};
            PMA_BASE_PAGE:  base_r[i]  <= csr_if.value_in[GW-1:0];
            PMA_LIMIT_PAGE: limit_r[i] <= csr_if.value_in[GW-1:0];
            default:        cfg_r[i]   <= cfg_r[i];
          endcase
        end else begin
          cfg_r[i] <= cfg_r[i];
        end
      end
    end
  end

  // Attribute lookup: iterate high to low so the lowest hit is left standing.
  always_comb begin
    dcfg_s = PMA_CFG_NONE;
    icfg_s = PMA_CFG_NONE;
    for (int i = NREGIONS - 1; i >= 0; i--) begin
      dcfg_s = d_hit_s[i] ? cfg_r[i].cfg : dcfg_s;
      icfg_s = i_hit_s[i] ? cfg_r[i].cfg : icfg_s;
    end
  end

  // Fault detection with load > store > fetch priority.
  always_comb begin
    l_raw_s  = pma_access_fault(ren, dcfg_s.R, d_acc_width, dcfg_s.AccWidth);
    s_raw_s  = pma_access_fault(wen, dcfg_s.W, d_acc_width, dcfg_s.AccWidth);
    i_raw_s  = pma_access_fault(xen, icfg_s.X, i_acc_width, icfg_s.AccWidth);
    l_flag_s = l_raw_s;
    s_flag_s = s_raw_s && !l_raw_s;
    i_flag_s = i_raw_s && !l_raw_s && !s_raw_s;
    any_fault_s  = l_raw_s || s_raw_s || i_raw_s;
    cause_s      = FAULT_NONE;
    fault_addr_s = 32'h0;
    if (l_flag_s) begin
      cause_s = FAULT_LOAD;  fault_addr_s = daddr;
    end else if (s_flag_s) begin
      cause_s = FAULT_STORE; fault_addr_s = daddr;
    end else if (i_flag_s) begin
      cause_s = FAULT_FETCH; fault_addr_s = iaddr;
    end else begin
      cause_s = FAULT_NONE;  fault_addr_s = 32'h0;
    end
  end

  // Registered fault pulses.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      pma_l_fault <= 1'b0;
      pma_s_fault <= 1'b0;
      pma_i_fault <= 1'b0;
    end else begin
      pma_l_fault <= l_flag_s;
      pma_s_fault <= s_flag_s;
      pma_i_fault <= i_flag_s;
    end
  end

  // Fault record next state: a clear in the same cycle as a fault re-captures.
  always_comb begin
    next_s    = state_r;
    capture_s = 1'b0;
    case (state_r)
      REC_IDLE: begin
        capture_s = any_fault_s;
        next_s    = any_fault_s ? REC_HELD : REC_IDLE;
      end
      REC_HELD: begin
        capture_s = any_fault_s && clear_s;
        next_s    = (clear_s && !any_fault_s) ? REC_IDLE : REC_HELD;
      end
      default: begin
        capture_s = 1'b0;
        next_s    = REC_IDLE;
      end
    endcase
  end

  // Fault record state and captured address/cause.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state_r     <= REC_IDLE;
      rec_addr_r  <= 32'h0;
      rec_cause_r <= FAULT_NONE;
    end else begin
      state_r <= next_s;
      if (capture_s) begin
        rec_addr_r  <= fault_addr_s;
        rec_cause_r <= cause_s;
      end else if (clear_s) begin
        rec_cause_r <= FAULT_NONE;
      end else begin
        rec_cause_r <= rec_cause_r;
      end
    end
  end

  assign fault_pend = (state_r == REC_HELD);

`ifdef PMA_FAULT_COUNT_EN
  logic [15:0] count_r;
  // Saturating fault counter; a CSR write in the same cycle takes precedence.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      count_r <= 16'h0;
    end else if (csr_if.csr_active && (csr_if.csr_addr == PMA_FAULT_COUNT_CSR)) begin
      count_r <= csr_if.value_in[15:0];
    end else if (any_fault_s && (count_r != 16'hFFFF)) begin
      count_r <= count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end
  assign count_rd_s = {16'h0, count_r};
`else
  assign count_rd_s = 32'h0;
`endif

  // CSR read mux, combinational from csr_addr.
  always_comb begin
    rdata_s = 32'h0;
    for (int i = 0; i < NREGIONS; i++) begin
      if (idx_s == 4'(i)) begin
        case (page_s)
          PMA_CFG_PAGE:   rdata_s = {cfg_r[i].L, cfg_r[i].EN, 18'h0, cfg_r[i].cfg};
          PMA_BASE_PAGE:  rdata_s = 32'(base_r[i]);
          PMA_LIMIT_PAGE: rdata_s = 32'(limit_r[i]);
          default:        rdata_s = rdata_s;
        endcase
      end else begin
        rdata_s = rdata_s;
      end
    end
    case (csr_if.csr_addr)
      PMA_FAULT_ADDR_CSR:  rdata_s = rec_addr_r;
      PMA_FAULT_CAUSE_CSR: rdata_s = {30'h0, rec_cause_r};
      PMA_FAULT_COUNT_CSR: rdata_s = count_rd_s;
      default:             rdata_s = rdata_s;
    endcase
  end

endmodule

// File: tb/tb_priv_1_12_pma_regions.sv
// Directed self-checking bench for priv_1_12_pma_regions (NREGIONS=8, GRAN_LOG2=12).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_priv_1_12_pma_regions;
  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] daddr, iaddr;
  logic        ren, wen, xen;
  logic [1:0]  d_acc_width, i_acc_width;
  logic        pma_l_fault, pma_s_fault, pma_i_fault, fault_pend;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] rd;

  priv_1_12_pma_regions_if bus();

  priv_1_12_pma_regions dut (
    .CLK(CLK), .nRST(nRST), .csr_if(bus),
    .daddr(daddr), .iaddr(iaddr), .ren(ren), .wen(wen), .xen(xen),
    .d_acc_width(d_acc_width), .i_acc_width(i_acc_width),
    .pma_l_fault(pma_l_fault), .pma_s_fault(pma_s_fault),
    .pma_i_fault(pma_i_fault), .fault_pend(fault_pend)
  );

  always #5 CLK = ~CLK;

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge CLK);
    bus.csr_addr = a; bus.value_in = d; bus.csr_active = 1'b1;
    @(negedge CLK);
    bus.csr_active = 1'b0;
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
    bus.csr_addr = a;
    #1;
    d = bus.value_out;
  endtask

  // One-cycle request; returns on the next falling edge where its fault is visible.
  task automatic access(input logic r, input logic w, input logic x,
                        input logic [31:0] da, input logic [31:0] ia);
    @(negedge CLK);
    ren = r; wen = w; xen = x; daddr = da; iaddr = ia;
    d_acc_width = 2'b10; i_acc_width = 2'b10;
    @(negedge CLK);
    ren = 1'b0; wen = 1'b0; xen = 1'b0;
  endtask

  task automatic test_reset;
    vectors++; if ({pma_l_fault, pma_s_fault, pma_i_fault, fault_pend} !== 4'b0000) begin miscompares++; $display("FAIL reset_outputs: got %b want 0000", {pma_l_fault, pma_s_fault, pma_i_fault, fault_pend}); end
    csr_rd(12'hBC0, rd); vectors++; if (rd !== 32'h4000_08E5) begin miscompares++; $display("FAIL reset_cfg0: got %h want 400008e5", rd); end
    csr_rd(12'hBC1, rd); vectors++; if (rd !== 32'h4000_08FF) begin miscompares++; $display("FAIL reset_cfg1: got %h want 400008ff", rd); end
    csr_rd(12'hBC2, rd); vectors++; if (rd !== 32'h4000_0806) begin miscompares++; $display("FAIL reset_cfg2: got %h want 40000806", rd); end
    csr_rd(12'hBC3, rd); vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL reset_cfg3: got %h want 0", rd); end
    csr_rd(12'hBE1, rd); vectors++; if (rd !== 32'h0007_FFFF) begin miscompares++; $display("FAIL reset_limit1: got %h want 7ffff", rd); end
    csr_rd(12'hBD2, rd); vectors++; if (rd !== 32'h0008_0000) begin miscompares++; $display("FAIL reset_base2: got %h want 80000", rd); end
  endtask

  task automatic test_rom_access;
    access(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0);
    vectors++; if (pma_l_fault !== 1'b0) begin miscompares++; $display("FAIL rom_load: got %b want 0", pma_l_fault); end
    access(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    vectors++; if (pma_s_fault !== 1'b1) begin miscompares++; $display("FAIL rom_store: got %b want 1", pma_s_fault); end
    vectors++; if (fault_pend !== 1'b1) begin miscompares++; $display("FAIL rom_pend: got %b want 1", fault_pend); end
    csr_rd(12'hBF1, rd); vectors++; if (rd !== 32'd2) begin miscompares++; $display("FAIL rom_cause: got %h want 2", rd); end
    csr_rd(12'hBF0, rd); vectors++; if (rd !== 32'h100) begin miscompares++; $display("FAIL rom_addr: got %h want 100", rd); end
    @(negedge CLK);
    vectors++; if (pma_s_fault !== 1'b0) begin miscompares++; $display("FAIL rom_pulse_width: got %b want 0", pma_s_fault); end
  endtask

  task automatic test_region_priority;
    csr_wr(12'hBD3, 32'h0002_0000);
    csr_wr(12'hBE3, 32'h0002_0000);
    csr_wr(12'hBC3, 32'h4000_0804);
    access(1'b0, 1'b1, 1'b0, 32'h2000_0004, 32'h0);
    vectors++; if (pma_s_fault !== 1'b0) begin miscompares++; $display("FAIL prio_region1_wins: got %b want 0", pma_s_fault); end
    csr_wr(12'hBD1, 32'h0002_0001);
    csr_wr(12'hBF1, 32'h0);
    access(1'b0, 1'b1, 1'b0, 32'h2000_0004, 32'h0);
    vectors++; if (pma_s_fault !== 1'b1) begin miscompares++; $display("FAIL prio_region3_store: got %b want 1", pma_s_fault); end
    csr_rd(12'hBF0, rd); vectors++; if (rd !== 32'h2000_0004) begin miscompares++; $display("FAIL prio_addr: got %h want 20000004", rd); end
    access(1'b0, 1'b1, 1'b0, 32'h2000_1000, 32'h0);
    vectors++; if (pma_s_fault !== 1'b0) begin miscompares++; $display("FAIL prio_past_limit: got %b want 0", pma_s_fault); end
  endtask

  task automatic test_lock;
    csr_wr(12'hBC3, 32'hC000_0804);
    csr_wr(12'hBD3, 32'h0);
    csr_rd(12'hBD3, rd); vectors++; if (rd !== 32'h0002_0000) begin miscompares++; $display("FAIL lock_base: got %h want 20000", rd); end
    csr_wr(12'hBC3, 32'h0000_08FF);
    csr_rd(12'hBC3, rd); vectors++; if (rd !== 32'hC000_0804) begin miscompares++; $display("FAIL lock_cfg: got %h want c0000804", rd); end
    csr_wr(12'hBF1, 32'h0);
    vectors++; if (fault_pend !== 1'b0) begin miscompares++; $display("FAIL lock_clear_pend: got %b want 0", fault_pend); end
  endtask

  task automatic test_fault_record;
    access(1'b1, 1'b0, 1'b1, 32'h1000_0000, 32'h1000_0000);
    vectors++; if ({pma_l_fault, pma_s_fault, pma_i_fault} !== 3'b100) begin miscompares++; $display("FAIL rec_lsi: got %b want 100", {pma_l_fault, pma_s_fault, pma_i_fault}); end
    csr_rd(12'hBF1, rd); vectors++; if (rd !== 32'd1) begin miscompares++; $display("FAIL rec_cause_l: got %h want 1", rd); end
    access(1'b0, 1'b0, 1'b1, 32'h0, 32'h1000_0040);
    vectors++; if (pma_i_fault !== 1'b1) begin miscompares++; $display("FAIL rec_fetch: got %b want 1", pma_i_fault); end
    csr_rd(12'hBF1, rd); vectors++; if (rd !== 32'd1) begin miscompares++; $display("FAIL rec_held_cause: got %h want 1", rd); end
    csr_rd(12'hBF0, rd); vectors++; if (rd !== 32'h1000_0000) begin miscompares++; $display("FAIL rec_held_addr: got %h want 10000000", rd); end
    // Clear and a new store fault in the same cycle.
    @(negedge CLK);
    bus.csr_addr = 12'hBF1; bus.value_in = 32'h0; bus.csr_active = 1'b1;
    wen = 1'b1; daddr = 32'h0000_0100; d_acc_width = 2'b10;
    @(negedge CLK);
    bus.csr_active = 1'b0; wen = 1'b0;
    vectors++; if (fault_pend !== 1'b1) begin miscompares++; $display("FAIL rec_clear_fault_pend: got %b want 1", fault_pend); end
    csr_rd(12'hBF1, rd); vectors++; if (rd !== 32'd2) begin miscompares++; $display("FAIL rec_clear_fault_cause: got %h want 2", rd); end
    csr_rd(12'hBF0, rd); vectors++; if (rd !== 32'h100) begin miscompares++; $display("FAIL rec_clear_fault_addr: got %h want 100", rd); end
  endtask

  task automatic test_warl;
    csr_wr(12'hBC4, 32'h4000_0F06);
    csr_rd(12'hBC4, rd); vectors++; if (rd !== 32'h4000_0806) begin miscompares++; $display("FAIL warl_cfg: got %h want 40000806", rd); end
    csr_rd(12'hBC8, rd);
    vectors++; if ({bus.ack, bus.invalid_csr} !== 2'b11) begin miscompares++; $display("FAIL warl_invalid_bc8: got %b want 11", {bus.ack, bus.invalid_csr}); end
    csr_rd(12'hBC7, rd);
    vectors++; if ({bus.ack, bus.invalid_csr} !== 2'b10) begin miscompares++; $display("FAIL warl_valid_bc7: got %b want 10", {bus.ack, bus.invalid_csr}); end
    csr_rd(12'hBF3, rd);
    vectors++; if (bus.ack !== 1'b0) begin miscompares++; $display("FAIL warl_unmapped_bf3: got %b want 0", bus.ack); end
  endtask

  task automatic test_fault_count;
`ifdef PMA_FAULT_COUNT_EN
    csr_wr(12'hBF2, 32'h0);
    for (int k = 0; k < 3; k++) access(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    csr_rd(12'hBF2, rd); vectors++; if (rd !== 32'd3) begin miscompares++; $display("FAIL count_three: got %h want 3", rd); end
    csr_wr(12'hBF2, 32'h0000_FFFF);
    access(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    csr_rd(12'hBF2, rd); vectors++; if (rd !== 32'h0000_FFFF) begin miscompares++; $display("FAIL count_saturate: got %h want ffff", rd); end
`else
    csr_wr(12'hBF2, 32'h0000_1234);
    csr_rd(12'hBF2, rd); vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL count_absent_read: got %h want 0", rd); end
    vectors++; if ({bus.ack, bus.invalid_csr} !== 2'b10) begin miscompares++; $display("FAIL count_absent_ack: got %b want 10", {bus.ack, bus.invalid_csr}); end
`endif
  endtask

  task automatic test_reset_mid;
    @(negedge CLK);
    wen = 1'b1; daddr = 32'h0000_0100; d_acc_width = 2'b10;
    #2 nRST = 1'b0;
    @(posedge CLK); #1;
    vectors++; if ({pma_s_fault, fault_pend} !== 2'b00) begin miscompares++; $display("FAIL mid_reset_outputs: got %b want 00", {pma_s_fault, fault_pend}); end
    csr_rd(12'hBC3, rd); vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL mid_reset_cfg3: got %h want 0", rd); end
    @(negedge CLK);
    wen = 1'b0; nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0; ren = 1'b0; wen = 1'b0; xen = 1'b0;
    daddr = 32'h0; iaddr = 32'h0; d_acc_width = 2'b10; i_acc_width = 2'b10;
    bus.csr_addr = 12'h0; bus.csr_active = 1'b0; bus.value_in = 32'h0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    test_reset;
    test_rom_access;
    test_region_priority;
    test_lock;
    test_fault_record;
    test_warl;
    test_fault_count;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
